// File: rtl/mux_tree_pipe.sv
// Pipelined radix-2**S multiplexer tree with valid/ready flow control.
// Each stage consumes S select bits (LSBs first) and registers data, valid, err and the remaining select bits.
module mux_tree_pipe #(
  parameter int W      = 4,
  parameter int NUM_IN = 128,
  parameter int S      = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [W-1:0]              data_i [NUM_IN],
  input  logic [$clog2(NUM_IN)-1:0] sel_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [W-1:0]              data_o,
  output logic                      err_o,
  output logic                      valid_o,
  input  logic                      ready_i
);
  localparam int SEL_W = $clog2(NUM_IN);
  localparam int L     = (SEL_W + S - 1) / S;
  localparam int PS    = L * S;
  localparam int P     = 2 ** PS;
  localparam int R     = 2 ** S;

  logic                en;
  logic [P-1:0][W-1:0] leaf_pad;
  logic [P-1:0][W-1:0] lvl_data  [L+1];
  logic [PS-1:0]       lvl_sel   [L];
  logic                lvl_valid [L+1];
  logic                lvl_err   [L+1];

  // A single enable freezes every stage, bubbles included, when the output is stalled.
  assign en      = !valid_o || ready_i;
  assign ready_o = en;

  always_comb begin
    leaf_pad = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      leaf_pad[i] = data_i[i];
    end
  end

  assign lvl_data[0]  = leaf_pad;
  assign lvl_valid[0] = valid_i;
  assign lvl_err[0]   = valid_i && (32'(sel_i) >= NUM_IN);
  assign lvl_sel[0]   = PS'(sel_i);

  generate
    for (genvar gi = 0; gi < L; gi++) begin : g_stage
      localparam int NOUT = P >> (S * (gi + 1));

      logic [P-1:0][W-1:0] data_d, data_q;
      logic                valid_d, valid_q;
      logic                err_d, err_q;
      logic [R-1:0][W-1:0] grp;
      logic [S-1:0]        chunk;

      assign chunk = lvl_sel[gi][S-1:0];

      always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;
        grp     = '0;
        if (en) begin
          valid_d = lvl_valid[gi];
          err_d   = lvl_err[gi];
          data_d  = '0;
          for (int j = 0; j < NOUT; j++) begin
            grp       = lvl_data[gi][j*R +: R];
            data_d[j] = grp[chunk];
          end
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          data_q  <= '0;
          valid_q <= 1'b0;
          err_q   <= 1'b0;
        end else begin
          data_q  <= data_d;
          valid_q <= valid_d;
          err_q   <= err_d;
        end
      end

      assign lvl_data[gi+1]  = data_q;
      assign lvl_valid[gi+1] = valid_q;
      assign lvl_err[gi+1]   = err_q;

      // The last stage has no select bits left to carry.
      if (gi < L - 1) begin : g_sel
        logic [PS-1:0] sel_d, sel_q;

        assign sel_d = en ? (lvl_sel[gi] >> S) : sel_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            sel_q <= '0;
          end else begin
            sel_q <= sel_d;
          end
        end

        assign lvl_sel[gi+1] = sel_q;
      end
    end
  endgenerate

  assign data_o  = lvl_data[L][0];
  assign err_o   = lvl_err[L];
  assign valid_o = lvl_valid[L];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe: default geometry against a latency-line model,
// plus NUM_IN=100 and W=8/NUM_IN=5/S=1 geometries checked request by request.
module tb_mux_tree_pipe;
  localparam int W    = 4;
  localparam int N    = 128;
  localparam int LAT  = 4;
  localparam int EN   = 100;
  localparam int ELAT = 4;
  localparam int FW   = 8;
  localparam int FN   = 5;
  localparam int FLAT = 3;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [W-1:0] d_data [N];
  logic [6:0]   d_sel;
  logic         d_valid, d_ready_i, d_ready_o, d_valid_o, d_err_o;
  logic [W-1:0] d_data_o;

  logic [W-1:0] e_data [EN];
  logic [6:0]   e_sel;
  logic         e_valid, e_ready_i, e_ready_o, e_valid_o, e_err_o;
  logic [W-1:0] e_data_o;

  logic [FW-1:0] f_data [FN];
  logic [2:0]    f_sel;
  logic          f_valid, f_ready_i, f_ready_o, f_valid_o, f_err_o;
  logic [FW-1:0] f_data_o;

  mux_tree_pipe #(.W(W), .NUM_IN(N), .S(2)) u_def (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_i(d_data), .sel_i(d_sel), .valid_i(d_valid),
    .ready_o(d_ready_o), .data_o(d_data_o), .err_o(d_err_o), .valid_o(d_valid_o), .ready_i(d_ready_i)
  );

  mux_tree_pipe #(.W(W), .NUM_IN(EN), .S(2)) u_n100 (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_i(e_data), .sel_i(e_sel), .valid_i(e_valid),
    .ready_o(e_ready_o), .data_o(e_data_o), .err_o(e_err_o), .valid_o(e_valid_o), .ready_i(e_ready_i)
  );

  mux_tree_pipe #(.W(FW), .NUM_IN(FN), .S(1)) u_odd (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_i(f_data), .sel_i(f_sel), .valid_i(f_valid),
    .ready_o(f_ready_o), .data_o(f_data_o), .err_o(f_err_o), .valid_o(f_valid_o), .ready_i(f_ready_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model of u_def: a request is the selected channel value, delayed by LAT accepted slots.
  bit           m_v [LAT];
  logic [W-1:0] m_d [LAT];

  function automatic bit model_en();
    return !m_v[LAT-1] || d_ready_i;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < LAT; k++) begin
      m_v[k] = 1'b0;
      m_d[k] = '0;
    end
  endtask

  task automatic model_tick();
    if (!rst_ni) begin
      model_clear();
    end else if (model_en()) begin
      for (int k = LAT - 1; k > 0; k--) begin
        m_v[k] = m_v[k-1];
        m_d[k] = m_d[k-1];
      end
      m_v[0] = d_valid;
      m_d[0] = d_data[d_sel];
    end
  endtask

  task automatic drive_cycle();
    @(posedge clk_i);
    model_tick();
    #1;
  endtask

  task automatic ramp_data();
    for (int k = 0; k < N; k++) d_data[k] = 4'(k % 16);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    model_clear();
    d_valid = 1'b1;
    d_sel = 7'd3;
    d_ready_i = 1'b0;
    repeat (3) drive_cycle();
    n_checks++;
    if (d_valid_o !== 1'b0 || d_data_o !== 4'h0 || d_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%0b data=%0h err=%0b expected 0/0/0", d_valid_o, d_data_o, d_err_o);
    end
    n_checks++;
    if (d_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %0b expected 1", d_ready_o);
    end
    n_checks++;
    if (e_valid_o !== 1'b0 || f_valid_o !== 1'b0 || f_data_o !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_other_geom: got e_valid=%0b f_valid=%0b f_data=%0h expected 0/0/0", e_valid_o, f_valid_o, f_data_o);
    end
    rst_ni = 1'b1;
    d_valid = 1'b0;
    d_ready_i = 1'b1;
  endtask

  task automatic test_single();
    ramp_data();
    d_sel = 7'd85;
    d_valid = 1'b1;
    d_ready_i = 1'b1;
    drive_cycle();
    d_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if (d_valid_o !== (c == LAT)) begin
        n_fail++;
        $display("FAIL single_valid cycle %0d: got %0b expected %0b", c, d_valid_o, (c == LAT));
      end
      if (c == LAT) begin
        n_checks++;
        if (d_data_o !== 4'(85 % 16) || d_err_o !== 1'b0) begin
          n_fail++;
          $display("FAIL single_data: got data=%0h err=%0b expected data=%0h err=0", d_data_o, d_err_o, 85 % 16);
        end
      end
      drive_cycle();
    end
  endtask

  task automatic test_stream();
    bit exp_v;
    ramp_data();
    d_ready_i = 1'b1;
    for (int c = 0; c < N + LAT + 2; c++) begin
      d_valid = (c < N);
      d_sel = 7'(c);
      #1;
      exp_v = (c >= LAT) && (c < LAT + N);
      n_checks++;
      if (d_valid_o !== exp_v || d_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_valid cycle %0d: got valid=%0b ready=%0b expected valid=%0b ready=1", c, d_valid_o, d_ready_o, exp_v);
      end
      if (exp_v) begin
        n_checks++;
        if (d_data_o !== 4'((c - LAT) % 16) || d_err_o !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_data cycle %0d: got data=%0h err=%0b expected data=%0h err=0", c, d_data_o, d_err_o, (c - LAT) % 16);
        end
      end
      drive_cycle();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      d_valid = ($urandom_range(0, 3) != 0);
      d_sel = 7'($urandom);
      for (int k = 0; k < N; k++) d_data[k] = 4'($urandom);
      d_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (d_ready_o !== model_en() || d_valid_o !== m_v[LAT-1]) begin
        n_fail++;
        $display("FAIL random_ctrl cycle %0d: got ready=%0b valid=%0b expected ready=%0b valid=%0b", c, d_ready_o, d_valid_o, model_en(), m_v[LAT-1]);
      end
      if (m_v[LAT-1]) begin
        n_checks++;
        if (d_data_o !== m_d[LAT-1] || d_err_o !== 1'b0) begin
          n_fail++;
          $display("FAIL random_data cycle %0d: got data=%0h err=%0b expected data=%0h err=0", c, d_data_o, d_err_o, m_d[LAT-1]);
        end
      end
      drive_cycle();
    end
    d_valid = 1'b0;
    d_ready_i = 1'b1;
    repeat (LAT + 1) drive_cycle();
  endtask

  task automatic test_back_to_back_stall();
    logic [W-1:0] exp_q [$];
    int bp_sel [6] = '{3, 77, 12, 127, 64, 0};
    int sent = 0;
    int got = 0;
    int stall = 0;
    bit stalled = 1'b0;
    for (int k = 0; k < N; k++) d_data[k] = 4'($urandom);
    for (int c = 0; c < 30; c++) begin
      d_valid = (sent < 6);
      d_sel = 7'(bp_sel[(sent < 6) ? sent : 0]);
      if (!stalled && m_v[LAT-1]) begin
        stalled = 1'b1;
        stall = 3;
      end
      d_ready_i = (stall == 0);
      #1;
      n_checks++;
      if (d_ready_o !== model_en() || d_valid_o !== m_v[LAT-1] || (m_v[LAT-1] && d_data_o !== m_d[LAT-1])) begin
        n_fail++;
        $display("FAIL stall_cycle %0d: got ready=%0b valid=%0b data=%0h expected ready=%0b valid=%0b data=%0h",
                 c, d_ready_o, d_valid_o, d_data_o, model_en(), m_v[LAT-1], m_d[LAT-1]);
      end
      if (stall > 0) begin
        n_checks++;
        if (d_ready_o !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_ready cycle %0d: got %0b expected 0", c, d_ready_o);
        end
      end
      if (d_valid_o && d_ready_i) begin
        n_checks++;
        if (exp_q.size() == 0 || d_data_o !== exp_q[0]) begin
          n_fail++;
          $display("FAIL stall_order cycle %0d: got data=%0h expected %0h (pending %0d)", c, d_data_o,
                   (exp_q.size() != 0) ? exp_q[0] : 4'h0, exp_q.size());
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      if (d_valid && model_en()) begin
        exp_q.push_back(d_data[d_sel]);
        sent++;
      end
      if (stall > 0) stall--;
      drive_cycle();
    end
    d_valid = 1'b0;
    d_ready_i = 1'b1;
    n_checks++;
    if (got != 6 || exp_q.size() != 0 || sent != 6) begin
      n_fail++;
      $display("FAIL stall_count: got delivered=%0d sent=%0d pending=%0d expected 6/6/0", got, sent, exp_q.size());
    end
  endtask

  task automatic test_reset_midop();
    int rq_sel [3] = '{10, 20, 30};
    ramp_data();
    d_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      d_valid = (c < 3);
      d_sel = 7'(rq_sel[(c < 3) ? c : 0]);
      #1;
      n_checks++;
      if (d_valid_o !== m_v[LAT-1] || (m_v[LAT-1] && d_data_o !== m_d[LAT-1])) begin
        n_fail++;
        $display("FAIL midop_pre cycle %0d: got valid=%0b data=%0h expected valid=%0b data=%0h", c, d_valid_o, d_data_o, m_v[LAT-1], m_d[LAT-1]);
      end
      drive_cycle();
    end
    d_valid = 1'b0;
    rst_ni = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (d_valid_o !== 1'b0 || d_data_o !== 4'h0 || d_err_o !== 1'b0 || d_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_async: got valid=%0b data=%0h err=%0b ready=%0b expected 0/0/0/1", d_valid_o, d_data_o, d_err_o, d_ready_o);
    end
    drive_cycle();
    rst_ni = 1'b1;
    d_valid = 1'b1;
    d_sel = 7'd7;
    drive_cycle();
    d_valid = 1'b0;
    for (int c = 1; c <= LAT + 4; c++) begin
      n_checks++;
      if (d_valid_o !== (c == LAT)) begin
        n_fail++;
        $display("FAIL midop_post_valid cycle %0d: got %0b expected %0b", c, d_valid_o, (c == LAT));
      end
      if (c == LAT) begin
        n_checks++;
        if (d_data_o !== 4'd7 || d_err_o !== 1'b0) begin
          n_fail++;
          $display("FAIL midop_post_data: got data=%0h err=%0b expected 7/0", d_data_o, d_err_o);
        end
      end
      drive_cycle();
    end
  endtask

  task automatic test_num_in_100();
    int sels [8] = '{99, 100, 127, 0, 1, 64, 98, 113};
    logic [W-1:0] exp_d;
    bit exp_e;
    e_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < EN; k++) e_data[k] = 4'($urandom);
      e_sel = 7'(sels[i]);
      e_valid = 1'b1;
      exp_e = (sels[i] >= EN);
      exp_d = exp_e ? 4'h0 : e_data[sels[i]];
      drive_cycle();
      e_valid = 1'b0;
      for (int c = 1; c <= ELAT + 1; c++) begin
        n_checks++;
        if (e_valid_o !== (c == ELAT)) begin
          n_fail++;
          $display("FAIL n100_valid sel=%0d cycle %0d: got %0b expected %0b", sels[i], c, e_valid_o, (c == ELAT));
        end
        if (c == ELAT) begin
          n_checks++;
          if (e_data_o !== exp_d || e_err_o !== exp_e) begin
            n_fail++;
            $display("FAIL n100_data sel=%0d: got data=%0h err=%0b expected data=%0h err=%0b", sels[i], e_data_o, e_err_o, exp_d, exp_e);
          end
        end
        drive_cycle();
      end
    end
  endtask

  task automatic test_odd_geometry();
    logic [FW-1:0] exp_d;
    bit exp_e;
    f_ready_i = 1'b1;
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < FN; k++) f_data[k] = {4'(k + 1), 4'($urandom)};
      f_sel = 3'(s);
      f_valid = 1'b1;
      exp_e = (s >= FN);
      exp_d = 8'h00;
      if (!exp_e) exp_d = f_data[s];
      drive_cycle();
      f_valid = 1'b0;
      for (int c = 1; c <= FLAT + 1; c++) begin
        n_checks++;
        if (f_valid_o !== (c == FLAT)) begin
          n_fail++;
          $display("FAIL odd_valid sel=%0d cycle %0d: got %0b expected %0b", s, c, f_valid_o, (c == FLAT));
        end
        if (c == FLAT) begin
          n_checks++;
          if (f_data_o !== exp_d || f_err_o !== exp_e) begin
            n_fail++;
            $display("FAIL odd_data sel=%0d: got data=%0h err=%0b expected data=%0h err=%0b", s, f_data_o, f_err_o, exp_d, exp_e);
          end
        end
        drive_cycle();
      end
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) d_data[k] = '0;
    for (int k = 0; k < EN; k++) e_data[k] = '0;
    for (int k = 0; k < FN; k++) f_data[k] = '0;
    d_sel = '0; d_valid = 1'b0; d_ready_i = 1'b1;
    e_sel = '0; e_valid = 1'b0; e_ready_i = 1'b1;
    f_sel = '0; f_valid = 1'b0; f_ready_i = 1'b1;
    model_clear();
    test_reset();
    test_single();
    test_stream();
    test_random();
    test_back_to_back_stall();
    test_reset_midop();
    test_num_in_100();
    test_odd_geometry();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
